// File: rtl/mux_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mux_pkg
// Description : Shared constants, select type and one-hot decode helper for
//               the mux4_to_1 leaf selector.
// Revision    : 1.0 - initial release
// ============================================================================
package mux_pkg;

  localparam int SEL_W     = 2;
  localparam int NUM_LANES = 4;

  typedef logic [SEL_W-1:0] sel2_t;

  // One-hot decode of a lane select: bit s of the result is set.
  function automatic logic [NUM_LANES-1:0] decode_sel(input sel2_t s);
    logic [NUM_LANES-1:0] one;
    one = NUM_LANES'(1);
    return one << s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mux_2_1.sv
`default_nettype none
// ============================================================================
// Module      : mux_2_1
// Description : WIDTH-parameterised 2:1 selector; y = s ? b : a.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_2_1 #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             s,
  output logic [WIDTH-1:0] y
);

  generate
    if (WIDTH > 1) begin : g_wide
      // Per-bit select so each bit maps onto an independent 2:1 cell.
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign y[i] = s ? b[i] : a[i];
      end
    end else begin : g_narrow
      assign y = s ? b : a;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/mux4_to_1.sv
`default_nettype none
// ============================================================================
// Module      : mux4_to_1
// Description : Four-lane selector built as a two-level 2:1 tree. Provides a
//               zero-latency combinational output for tree composition, a
//               one-hot select decode, and registered copies of the selected
//               data and select for pipeline-stage use.
// Revision    : 1.0 - initial release
// ============================================================================
module mux4_to_1
  import mux_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_LANES*WIDTH-1:0] in,
  input  sel2_t                      sel,
  output logic [WIDTH-1:0]           out,
  output logic [WIDTH-1:0]           out_q,
  output logic [NUM_LANES-1:0]       sel_oh,
  output sel2_t                      sel_q
);

  logic [WIDTH-1:0] lo_pair;
  logic [WIDTH-1:0] hi_pair;

  // First level: sel[0] picks within lanes 0/1 and lanes 2/3.
  mux_2_1 #(.WIDTH(WIDTH)) u_mux_lo (
    .a (in[0*WIDTH +: WIDTH]),
    .b (in[1*WIDTH +: WIDTH]),
    .s (sel[0]),
    .y (lo_pair)
  );

  mux_2_1 #(.WIDTH(WIDTH)) u_mux_hi (
    .a (in[2*WIDTH +: WIDTH]),
    .b (in[3*WIDTH +: WIDTH]),
    .s (sel[0]),
    .y (hi_pair)
  );

  // Second level: sel[1] picks between the two pairs. No clock or reset on
  // this path, so wide trees can be composed from these leaves.
  mux_2_1 #(.WIDTH(WIDTH)) u_mux_out (
    .a (lo_pair),
    .b (hi_pair),
    .s (sel[1]),
    .y (out)
  );

  // One-hot decode of the select; exactly one bit set for any legal sel.
  always_comb begin
    sel_oh = decode_sel(sel);
  end

  // Registered copies of the selected data and select; reset clears at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_q <= '0;
      sel_q <= '0;
    end else begin
      out_q <= out;
      sel_q <= sel;
    end
  end

`ifndef SYNTHESIS
  a_sel_onehot : assert property (@(posedge clk) $onehot(sel_oh))
    else $error("sel_oh not one-hot: %b", sel_oh);

  // Only meaningful once the register has been out of reset for a full cycle.
  a_out_q_tracks : assert property (@(posedge clk) disable iff (!reset_n)
      $past(reset_n) |-> (out_q == $past(out)))
    else $error("out_q does not match previous out");
`endif

endmodule
`default_nettype wire

// File: tb/tb_mux4_to_1.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux4_to_1
// Description : Directed self-checking bench for mux4_to_1: reset behaviour,
//               walking-one selection, all-zero/all-one data, one-hot decode,
//               registered latency, a 16:1 tree of five leaves and WIDTH=8.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux4_to_1;

  logic       clk;
  logic       reset_n;

  // Single-bit leaf under direct test.
  logic [3:0] in;
  logic [1:0] sel;
  logic       out;
  logic       out_q;
  logic [3:0] sel_oh;
  logic [1:0] sel_q;

  // 16:1 composition of five leaves.
  logic [15:0] tin;
  logic [3:0]  tsel;
  logic [3:0]  leaf;
  logic [3:0]  leaf_q;
  logic [3:0]  leaf_oh [4];
  logic [1:0]  leaf_sq [4];
  logic        tout;
  logic        tout_q;
  logic [3:0]  root_oh;
  logic [1:0]  root_sq;

  // Eight-bit lanes.
  logic [31:0] win;
  logic [1:0]  wsel;
  logic [7:0]  wout;
  logic [7:0]  wout_q;
  logic [3:0]  woh;
  logic [1:0]  wsq;

  int n_checks;
  int n_errors;

  mux4_to_1 #(.WIDTH(1)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .in      (in),
    .sel     (sel),
    .out     (out),
    .out_q   (out_q),
    .sel_oh  (sel_oh),
    .sel_q   (sel_q)
  );

  generate
    for (genvar i = 0; i < 4; i++) begin : g_leaf
      mux4_to_1 #(.WIDTH(1)) u_leaf (
        .clk     (clk),
        .reset_n (reset_n),
        .in      (tin[i*4 +: 4]),
        .sel     (tsel[1:0]),
        .out     (leaf[i]),
        .out_q   (leaf_q[i]),
        .sel_oh  (leaf_oh[i]),
        .sel_q   (leaf_sq[i])
      );
    end
  endgenerate

  mux4_to_1 #(.WIDTH(1)) u_root (
    .clk     (clk),
    .reset_n (reset_n),
    .in      (leaf),
    .sel     (tsel[3:2]),
    .out     (tout),
    .out_q   (tout_q),
    .sel_oh  (root_oh),
    .sel_q   (root_sq)
  );

  mux4_to_1 #(.WIDTH(8)) u_wide (
    .clk     (clk),
    .reset_n (reset_n),
    .in      (win),
    .sel     (wsel),
    .out     (wout),
    .out_q   (wout_q),
    .sel_oh  (woh),
    .sel_q   (wsq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [3:0] walk;
    logic [3:0] onehot;
    logic [3:0] lat_exp;
    logic [7:0] wexp [4];

    n_checks = 0;
    n_errors = 0;
    wexp[0] = 8'hAA; wexp[1] = 8'hBB; wexp[2] = 8'hCC; wexp[3] = 8'hDD;
    lat_exp = 4'b0101;

    // Reset held with all-ones data on lane 3.
    reset_n = 1'b0;
    in      = 4'b1111;
    sel     = 2'b11;
    tin     = '0;
    tsel    = '0;
    win     = '0;
    wsel    = '0;
    #1;
    check("rst_out_q",  32'(out_q),  32'h0);
    check("rst_sel_q",  32'(sel_q),  32'h0);
    check("rst_out",    32'(out),    32'h1);
    check("rst_sel_oh", 32'(sel_oh), 32'h8);
    @(posedge clk); #1;
    check("rst_hold_out_q", 32'(out_q), 32'h0);
    check("rst_hold_sel_q", 32'(sel_q), 32'h0);

    // Release and load on the next edge.
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    check("rel_out_q", 32'(out_q), 32'h1);
    check("rel_sel_q", 32'(sel_q), 32'h3);

    // Asynchronous reset mid-cycle; combinational path keeps tracking.
    #2 reset_n = 1'b0;
    #1;
    check("async_out_q", 32'(out_q), 32'h0);
    check("async_sel_q", 32'(sel_q), 32'h0);
    check("async_out",   32'(out),   32'h1);
    in = 4'b0111;
    #1;
    check("async_out_track", 32'(out), 32'h0);
    @(negedge clk); reset_n = 1'b1;

    // Walking one: only the matching select yields 1.
    for (int k = 0; k < 4; k++) begin
      walk = 4'b0001 << k;
      for (int s = 0; s < 4; s++) begin
        @(negedge clk);
        in  = walk;
        sel = 2'(s);
        #1;
        check("walk_out", 32'(out), (k == s) ? 32'h1 : 32'h0);
      end
    end

    // All-zero and all-one data, plus the one-hot decode for each select.
    for (int s = 0; s < 4; s++) begin
      onehot = 4'b0001 << s;
      @(negedge clk);
      in  = 4'b0000;
      sel = 2'(s);
      #1;
      check("zero_out", 32'(out),    32'h0);
      check("sel_oh",   32'(sel_oh), 32'(onehot));
      in = 4'b1111;
      #1;
      check("ones_out", 32'(out),    32'h1);
    end

    // Registered latency: sel steps each cycle over in=0101.
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      in  = 4'b0101;
      sel = 2'(s);
      @(posedge clk); #1;
      check("lat_out_q", 32'(out_q), 32'(lat_exp[s]));
      check("lat_sel_q", 32'(sel_q), 32'(s));
    end

    // Same-cycle change of sel and in: register takes the new lane's new value.
    @(negedge clk);
    in  = 4'b0100;
    sel = 2'b10;
    @(posedge clk); #1;
    check("same_cycle_out_q", 32'(out_q), 32'h1);

    // 16:1 composition.
    @(negedge clk);
    tin = 16'h0010; tsel = 4'b0100; #1;
    check("tree_sel4",  32'(tout), 32'h1);
    tsel = 4'b0110; #1;
    check("tree_sel6",  32'(tout), 32'h0);
    tin = 16'h0020; tsel = 4'b0101; #1;
    check("tree_sel5",  32'(tout), 32'h1);
    tsel = 4'b1001; #1;
    check("tree_sel9",  32'(tout), 32'h0);
    @(posedge clk); #1;
    check("tree_out_q", 32'(tout_q), 32'h0);

    // Eight-bit lanes.
    win = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      wsel = 2'(s);
      #1;
      check("wide_out", 32'(wout), 32'(wexp[s]));
      @(posedge clk); #1;
      check("wide_out_q", 32'(wout_q), 32'(wexp[s]));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
